// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART receiver:
//   rx_state_e  - receiver FSM states
//   PAR_*       - parity_mode encodings (2'b11 behaves as PAR_NONE)
//   ptr_width() - FIFO pointer width: index bits plus one wrap bit
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous FIFO with a registered head. The head register always holds
// the entry at the read pointer, so the head is valid the cycle after a push
// into an empty FIFO and advances the cycle after a pop.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   push_i, din_i    write request and data (taken when not full, or when a
//                    pop in the same cycle frees a slot)
//   pop_i            read request (ignored when empty)
//   dout_o           head entry
//   full_o, empty_o  status, from pointer MSB/index comparison
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wr_d    = wr_q + PW'(do_push);
    rd_d    = rd_q + PW'(do_pop);
    // When the slot being written becomes the next head, bypass the array.
    if (do_push && (rd_d == wr_q)) head_d = din_i;
    else                           head_d = mem_q[rd_d[AW-1:0]];
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

  assign dout_o = head_q;

endmodule

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Oversampling UART receiver with runtime data length (5..DBIT_MAX), parity
// and 1/2 stop bits, start-bit glitch rejection, framing/parity error flags
// and a receive FIFO with valid/ready handshake.
// Build option: define UART_RX_PARITY_EN to build the parity state and check;
// without it parity_mode is ignored and parity_err is tied to 0.
// Ports:
//   clk, reset         clock, synchronous active-low reset
//   rx                 asynchronous serial line (idles high)
//   s_tick             oversample enable, OS pulses per bit
//   data_bits          data length, clamped to 5..DBIT_MAX
//   parity_mode        00 none, 01 even, 10 odd, 11 none
//   stop2              0: one stop bit, 1: two stop bits
//   rx_done_tick       pulse per completed frame (stored or not)
//   dout, frame_err,
//   parity_err         FIFO head entry
//   rx_valid, rx_ready FIFO not empty / pop request
//   overrun            pulse when a completed frame is dropped (FIFO full)
// ---------------------------------------------------------------------------
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DBIT_MAX   = 8,
  parameter int OS         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  input  logic                s_tick,
  input  logic [3:0]          data_bits,
  input  logic [1:0]          parity_mode,
  input  logic                stop2,
  output logic                rx_done_tick,
  output logic [DBIT_MAX-1:0] dout,
  output logic                frame_err,
  output logic                parity_err,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                overrun
);

  localparam int            SW     = $clog2(OS);
  localparam logic [SW-1:0] S_MID  = SW'(OS/2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
  localparam logic [3:0]    DB_MIN = 4'd5;
  localparam logic [3:0]    DB_MAX = 4'(DBIT_MAX);
`ifdef UART_RX_PARITY_EN
  localparam int EW = DBIT_MAX + 2;
`else
  localparam int EW = DBIT_MAX + 1;
`endif

  logic [1:0]          sync_q;
  logic                rx_s;
  rx_state_e           state_q;
  logic [SW-1:0]       s_cnt_q;
  logic [3:0]          n_cnt_q;
  logic                stop_cnt_q;
  logic [3:0]          dbits_q, dbits_d;
  logic                stop2_q;
  logic [DBIT_MAX-1:0] data_q;
  logic                ferr_q;
  logic                rx_done_q, overrun_q;
  logic                frame_end, push_ok;
  logic [EW-1:0]       entry, head;
  logic                fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic [1:0]          par_q;
  logic                par_acc_q, perr_q, par_on;
`else
  logic                unused_parity_mode;
`endif

  // NOTE: non-blocking assignments make both stages sample on the same edge;
  // blocking ones would collapse the synchroniser into a single flop.
  always_ff @(posedge clk) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  // NOTE: default assignment first so every path drives dbits_d (no latch).
  always_comb begin
    dbits_d = data_bits;
    if (data_bits < DB_MIN)      dbits_d = DB_MIN;
    else if (data_bits > DB_MAX) dbits_d = DB_MAX;
  end

  // Frame completes on the sample tick of the last stop bit; the push and
  // the frame_err contribution of that final sample happen on the same edge.
  assign frame_end = (state_q == ST_STOP) && s_tick && (s_cnt_q == S_LAST) &&
                     (stop_cnt_q == stop2_q);
  assign push_ok   = !fifo_full || (rx_ready && !fifo_empty);

`ifdef UART_RX_PARITY_EN
  assign par_on = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign entry  = {perr_q, ferr_q | ~rx_s, data_q};
`else
  assign unused_parity_mode = ^parity_mode;
  assign entry = {ferr_q | ~rx_s, data_q};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      s_cnt_q    <= '0;
      n_cnt_q    <= '0;
      stop_cnt_q <= 1'b0;
      dbits_q    <= DB_MIN;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      ferr_q     <= 1'b0;
      rx_done_q  <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= PAR_NONE;
      par_acc_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      rx_done_q <= frame_end;
      overrun_q <= frame_end && !push_ok;
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            // Frame configuration is frozen here for the whole frame.
            dbits_q    <= dbits_d;
            stop2_q    <= stop2;
            s_cnt_q    <= '0;
            n_cnt_q    <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= parity_mode;
            par_acc_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (s_cnt_q == S_MID) begin
              // Line high again at mid start bit: a glitch, not a frame.
              s_cnt_q <= '0;
              state_q <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (s_cnt_q == S_LAST) begin
              s_cnt_q <= '0;
              for (int i = 0; i < DBIT_MAX; i++) begin
                if (n_cnt_q == 4'(i)) data_q[i] <= rx_s;
              end
`ifdef UART_RX_PARITY_EN
              par_acc_q <= par_acc_q ^ rx_s;
`endif
              if (n_cnt_q == dbits_q - 4'd1) begin
                n_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                state_q <= par_on ? ST_PARITY : ST_STOP;
`else
                state_q <= ST_STOP;
`endif
              end else begin
                n_cnt_q <= n_cnt_q + 4'd1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (s_cnt_q == S_LAST) begin
              s_cnt_q <= '0;
              // XOR over data and parity bit is 0 for a good even frame and
              // 1 for a good odd frame.
              perr_q  <= (par_acc_q ^ rx_s) != (par_q == PAR_ODD);
              state_q <= ST_STOP;
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (s_tick) begin
            if (s_cnt_q == S_LAST) begin
              s_cnt_q <= '0;
              if (!rx_s) ferr_q <= 1'b1;
              if (stop_cnt_q == stop2_q) state_q <= ST_IDLE;
              else                       stop_cnt_q <= 1'b1;
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (frame_end),
    .din_i   (entry),
    .pop_i   (rx_ready),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dout         = head[DBIT_MAX-1:0];
  assign frame_err    = head[DBIT_MAX];
`ifdef UART_RX_PARITY_EN
  assign parity_err   = head[DBIT_MAX+1];
`else
  assign parity_err   = 1'b0;
`endif
  assign rx_valid     = !fifo_empty;
  assign rx_done_tick = rx_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
// Scoreboard bench for uart_rx_param (DBIT_MAX=8, OS=16, FIFO_DEPTH=4).
// Stimulus pushes the hand-computed expected entry into exp_q before sending a
// frame; the monitor pops and compares whenever rx_valid && rx_ready.
// s_tick pulses one cycle in four. Inputs change on the falling edge; outputs
// are sampled 2 time units after the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_param;

  localparam int DBIT_MAX   = 8;
  localparam int OS         = 16;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [3:0] data_bits = 4'd8;
  logic [1:0] parity_mode = 2'b00;
  logic       stop2 = 1'b0;
  logic       rx_ready = 1'b0;
  logic       rx_done_tick, frame_err, parity_err, rx_valid, overrun;
  logic [7:0] dout;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   ovr_cnt = 0;

  uart_rx_param #(
    .DBIT_MAX   (DBIT_MAX),
    .OS         (OS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .data_bits    (data_bits),
    .parity_mode  (parity_mode),
    .stop2        (stop2),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      s_tick = (t == 3);
      t = (t + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [7:0] d, input logic ferr, input logic perr);
    exp_t e;
    e.data = d;
    e.ferr = ferr;
    e.perr = perr;
    return e;
  endfunction

  // Start bit, LSB-first data, optional parity bit (par < 0: none), then 1s.
  function automatic logic [15:0] mk_frame(input logic [8:0] d, input int nb, input int par);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < nb; i++) f[1+i] = d[i];
    if (par >= 0) f[1+nb] = par[0];
    return f;
  endfunction

  // Monitor: counts pulses and checks every popped entry against exp_q.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        if (rx_done_tick) done_cnt++;
        if (overrun) ovr_cnt++;
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pop: got dout 0x%0h, expected no entry", dout);
          end else begin
            e = exp_q.pop_front();
            check("pop_data", dout, e.data);
            check("pop_frame_err", frame_err, e.ferr);
            check("pop_parity_err", parity_err, e.perr);
          end
        end
      end
    end
  end

  task automatic wait_tick();
    do @(posedge clk); while (s_tick !== 1'b1);
  endtask

  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  task automatic set_ready(input logic v);
    @(negedge clk);
    #1;
    rx_ready = v;
  endtask

  task automatic send_bit(input logic b, input int ticks);
    @(negedge clk);
    rx = b;
    repeat (ticks) wait_tick();
  endtask

  task automatic idle(input int nbits);
    repeat (nbits * OS) wait_tick();
  endtask

  // The last bit is split at its sample tick (OS/2) so a pop can be placed
  // exactly in the cycle of the frame's push.
  task automatic send_frame(input logic [15:0] bits, input int n, input bit pop_at_end);
    for (int i = 0; i < n - 1; i++) send_bit(bits[i], OS);
    @(negedge clk);
    rx = bits[n-1];
    repeat (OS/2 - 1) wait_tick();
    if (pop_at_end) begin
      do begin
        @(negedge clk);
        #1;
      end while (s_tick !== 1'b1);
      rx_ready = 1'b1;
      @(negedge clk);
      #1;
      rx_ready = 1'b0;
    end else begin
      wait_tick();
    end
    repeat (OS/2) wait_tick();
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    int d0;
    int o0;

    // Reset values
    repeat (4) @(negedge clk);
    sample();
    check("rst_rx_valid", rx_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_done_tick", rx_done_tick, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(1);

    // 8N1 0xA5, held until rx_ready
    data_bits = 4'd8; parity_mode = 2'b00; stop2 = 1'b0;
    d0 = done_cnt;
    exp_q.push_back(mk_exp(8'hA5, 1'b0, 1'b0));
    send_frame(mk_frame(9'h0A5, 8, -1), 10, 1'b0);
    idle(1);
    check("a5_done_pulses", done_cnt - d0, 1);
    sample();
    check("a5_valid_held", rx_valid, 1);
    set_ready(1'b1);
    wait_drain("a5_drain");
    sample();
    check("a5_valid_after_pop", rx_valid, 0);

    // 7E2: 0x35 has four ones, so parity bit 0 is correct and 1 is wrong.
    // Without parity support the parity bit is taken as the first stop bit.
    data_bits = 4'd7; parity_mode = 2'b01; stop2 = 1'b1;
    d0 = done_cnt;
`ifdef UART_RX_PARITY_EN
    exp_q.push_back(mk_exp(8'h35, 1'b0, 1'b0));
    exp_q.push_back(mk_exp(8'h35, 1'b0, 1'b1));
`else
    exp_q.push_back(mk_exp(8'h35, 1'b1, 1'b0));
    exp_q.push_back(mk_exp(8'h35, 1'b0, 1'b0));
`endif
    send_frame(mk_frame(9'h035, 7, 0), 11, 1'b0);
    idle(1);
    send_frame(mk_frame(9'h035, 7, 1), 11, 1'b0);
    idle(1);
    wait_drain("e72_drain");
    check("e72_done_pulses", done_cnt - d0, 2);

    // Start glitch: low for 4 ticks only
    data_bits = 4'd8; parity_mode = 2'b00; stop2 = 1'b0;
    d0 = done_cnt;
    send_bit(1'b0, 4);
    send_bit(1'b1, 3 * OS);
    check("glitch_no_done", done_cnt - d0, 0);
    sample();
    check("glitch_no_valid", rx_valid, 0);

    // Framing error: 0x3C with a low stop bit
    d0 = done_cnt;
    exp_q.push_back(mk_exp(8'h3C, 1'b1, 1'b0));
    send_frame(mk_frame(9'h03C, 8, -1), 9, 1'b0);
    send_bit(1'b0, 12);
    send_bit(1'b1, 2 * OS);
    wait_drain("ferr_drain");
    check("ferr_done_pulses", done_cnt - d0, 1);

    // Overrun: five frames into four entries, nothing popped
    set_ready(1'b0);
    d0 = done_cnt;
    o0 = ovr_cnt;
    for (int k = 1; k <= 4; k++) exp_q.push_back(mk_exp(8'(k), 1'b0, 1'b0));
    for (int k = 1; k <= 5; k++) begin
      send_frame(mk_frame(9'(k), 8, -1), 10, 1'b0);
      if (k == 4) check("ovr_none_first4", ovr_cnt - o0, 0);
    end
    idle(1);
    check("ovr_fifth_pulse", ovr_cnt - o0, 1);
    check("ovr_done_pulses", done_cnt - d0, 5);
    sample();
    check("ovr_valid_full", rx_valid, 1);
    set_ready(1'b1);
    wait_drain("ovr_drain");
    sample();
    check("ovr_valid_empty", rx_valid, 0);

    // Same, but a pop coincides with the fifth push: nothing lost
    set_ready(1'b0);
    o0 = ovr_cnt;
    for (int k = 1; k <= 5; k++) exp_q.push_back(mk_exp(8'(k), 1'b0, 1'b0));
    for (int k = 1; k <= 5; k++) send_frame(mk_frame(9'(k), 8, -1), 10, k == 5);
    idle(1);
    check("ovr_pop_same_cycle", ovr_cnt - o0, 0);
    set_ready(1'b1);
    wait_drain("ovr2_drain");
    sample();
    check("ovr2_valid_empty", rx_valid, 0);

    // Reset during data bit 3 of 0xFF, then 0x5A
    d0 = done_cnt;
    send_bit(1'b0, OS);
    for (int b = 0; b < 3; b++) send_bit(1'b1, OS);
    send_bit(1'b1, OS/2);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    sample();
    check("midrst_valid", rx_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(8);
    check("midrst_no_done", done_cnt - d0, 0);
    exp_q.push_back(mk_exp(8'h5A, 1'b0, 1'b0));
    send_frame(mk_frame(9'h05A, 8, -1), 10, 1'b0);
    idle(1);
    wait_drain("midrst_drain");
    check("midrst_one_done", done_cnt - d0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
